// File: rtl/sc_fifo_thrx_if.sv
// Bus bundle for the show-ahead threshold FIFO: write/read requests, thresholds,
// the error-clear strobe and every status output. Clock and reset stay outside.
interface sc_fifo_thrx_if #(
    parameter int LPM_WIDTH  = 16,
    parameter int LPM_WIDTHU = 5
);
    logic [LPM_WIDTH-1:0]  data;
    logic                  wrreq;
    logic                  rdreq;
    logic [LPM_WIDTHU-1:0] ae_thr;
    logic [LPM_WIDTHU-1:0] af_thr;
    logic                  err_clr;
    logic [LPM_WIDTH-1:0]  q;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [LPM_WIDTHU-1:0] usedw;
    logic [LPM_WIDTHU-1:0] peak;
    logic                  overflow;
    logic                  underflow;

    // The producer/consumer side that drives requests and watches status
    modport master (
        output data, wrreq, rdreq, ae_thr, af_thr, err_clr,
        input  q, empty, full, almost_empty, almost_full, usedw, peak,
               overflow, underflow
    );

    // The FIFO itself
    modport slave (
        input  data, wrreq, rdreq, ae_thr, af_thr, err_clr,
        output q, empty, full, almost_empty, almost_full, usedw, peak,
               overflow, underflow
    );
endinterface

// File: rtl/sc_fifo_thrx.sv
// Single-clock show-ahead FIFO with almost-empty/almost-full thresholds,
// peak fill tracking and sticky overflow/underflow flags.
// Optional fall-through path: define SC_FIFO_BYPASS_EN to let a word written
// into an empty FIFO appear on q (and be consumable) in the same cycle.
module sc_fifo_thrx #(
    parameter int LPM_WIDTH    = 16,
    parameter int LPM_NUMWORDS = 16,
    parameter int LPM_WIDTHU   = 5
) (
    input logic           clock,
    input logic           sclr_n,
    sc_fifo_thrx_if.slave bus
);
    localparam int PW = LPM_WIDTHU - 1;
    localparam logic [LPM_WIDTHU-1:0] DEPTH = LPM_WIDTHU'(LPM_NUMWORDS);

    logic [LPM_WIDTH-1:0]  mem [LPM_NUMWORDS];
    logic [PW-1:0]         wrPtr;
    logic [PW-1:0]         rdPtr;
    logic [PW-1:0]         nextRdPtr;
    logic [LPM_WIDTHU-1:0] usedwReg;
    logic [LPM_WIDTHU-1:0] usedwNext;
    logic [LPM_WIDTHU-1:0] peakReg;
    logic [LPM_WIDTHU-1:0] peakNext;
    logic [LPM_WIDTH-1:0]  headReg;
    logic                  overflowReg;
    logic                  underflowReg;
    logic                  emptyNow;
    logic                  fullNow;
    logic                  wrOk;
    logic                  rdOk;
    logic                  overflowEvent;
    logic                  underflowEvent;

    assign fullNow = (usedwReg == DEPTH);

`ifdef SC_FIFO_BYPASS_EN
    logic bypassActive;
    assign bypassActive = (usedwReg == '0) && bus.wrreq;
    assign emptyNow     = (usedwReg == '0) && !bus.wrreq;
    assign bus.q        = bypassActive ? bus.data : headReg;
`else
    assign emptyNow = (usedwReg == '0);
    assign bus.q    = headReg;
`endif

    assign rdOk           = bus.rdreq && !emptyNow;
    assign wrOk           = bus.wrreq && (!fullNow || rdOk);
    assign overflowEvent  = bus.wrreq && !wrOk;
    assign underflowEvent = bus.rdreq && emptyNow;
    assign nextRdPtr      = rdOk ? rdPtr + PW'(1) : rdPtr;

    assign bus.empty        = emptyNow;
    assign bus.full         = fullNow;
    assign bus.usedw        = usedwReg;
    assign bus.peak         = peakReg;
    assign bus.overflow     = overflowReg;
    assign bus.underflow    = underflowReg;
    assign bus.almost_empty = (usedwReg <= bus.ae_thr);
    assign bus.almost_full  = (usedwReg >= bus.af_thr);

    // Next fill level and running maximum; a lone write never hits a full
    // FIFO and a lone read never hits an empty one, so no wrap is possible
    always_comb begin
        usedwNext = usedwReg;
        if (wrOk && !rdOk) begin
            usedwNext = usedwReg + LPM_WIDTHU'(1);
        end else if (rdOk && !wrOk) begin
            usedwNext = usedwReg - LPM_WIDTHU'(1);
        end
        peakNext = (usedwNext > peakReg) ? usedwNext : peakReg;
    end

    // Control state: pointers, fill count, peak and sticky error flags
    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            usedwReg     <= '0;
            peakReg      <= '0;
            overflowReg  <= 1'b0;
            underflowReg <= 1'b0;
        end else begin
            if (wrOk) begin
                wrPtr <= wrPtr + PW'(1);
            end
            rdPtr        <= nextRdPtr;
            usedwReg     <= usedwNext;
            peakReg      <= bus.err_clr ? '0 : peakNext;
            overflowReg  <= overflowEvent || (overflowReg && !bus.err_clr);
            underflowReg <= underflowEvent || (underflowReg && !bus.err_clr);
        end
    end

    // Storage array; never cleared, and writes are blocked while in reset
    always_ff @(posedge clock) begin
        if (sclr_n && wrOk) begin
            mem[wrPtr] <= bus.data;
        end
    end

    // Head register tracks the word at the next read pointer, forwarding the
    // incoming word when it lands exactly on that slot (empty or usedw=1 pop)
    always_ff @(posedge clock) begin
        if (wrOk && (wrPtr == nextRdPtr)) begin
            headReg <= bus.data;
        end else begin
            headReg <= mem[nextRdPtr];
        end
    end
endmodule

// File: tb/tb_sc_fifo_thrx.sv
// Self-checking bench for sc_fifo_thrx: a table of directed single-cycle
// vectors plus hand-written sequences for streaming, reset and corner cases.
// Build with SC_FIFO_BYPASS_EN defined to exercise the fall-through variant.
module tb_sc_fifo_thrx;
    logic clock = 1'b0;
    logic sclr_n;
    int   cmpCount = 0;
    int   failCount = 0;

    sc_fifo_thrx_if #(.LPM_WIDTH(16), .LPM_WIDTHU(5)) bus ();

    sc_fifo_thrx #(
        .LPM_WIDTH(16),
        .LPM_NUMWORDS(16),
        .LPM_WIDTHU(5)
    ) dut (
        .clock(clock),
        .sclr_n(sclr_n),
        .bus(bus)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clock = ~clock;

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic        clr;
        logic [15:0] din;
        logic [4:0]  expUsedw;
        logic [4:0]  expPeak;
        logic        expEmpty;
        logic        expFull;
        logic        expAe;
        logic        expAf;
        logic        expOvf;
        logic        expUdf;
        logic        chkQ;
        logic [15:0] expQ;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmpCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of requests, return to idle just after the edge
    task automatic applyStimulus(input logic wr, input logic rd, input logic clr, input logic [15:0] din);
        bus.wrreq   = wr;
        bus.rdreq   = rd;
        bus.err_clr = clr;
        bus.data    = din;
        @(posedge clock);
        #1;
        bus.wrreq   = 1'b0;
        bus.rdreq   = 1'b0;
        bus.err_clr = 1'b0;
        #1;
    endtask

    task automatic doReset();
        sclr_n    = 1'b0;
        bus.wrreq = 1'b1;
        bus.rdreq = 1'b1;
        bus.data  = 16'hDEAD;
        repeat (2) @(posedge clock);
        #1;
        bus.wrreq = 1'b0;
        bus.rdreq = 1'b0;
        sclr_n    = 1'b1;
        #1;
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        checkOutput({tag, ".usedw"}, 32'(bus.usedw), 32'(v.expUsedw));
        checkOutput({tag, ".peak"}, 32'(bus.peak), 32'(v.expPeak));
        checkOutput({tag, ".empty"}, 32'(bus.empty), 32'(v.expEmpty));
        checkOutput({tag, ".full"}, 32'(bus.full), 32'(v.expFull));
        checkOutput({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(v.expAe));
        checkOutput({tag, ".almost_full"}, 32'(bus.almost_full), 32'(v.expAf));
        checkOutput({tag, ".overflow"}, 32'(bus.overflow), 32'(v.expOvf));
        checkOutput({tag, ".underflow"}, 32'(bus.underflow), 32'(v.expUdf));
        if (v.chkQ) begin
            checkOutput({tag, ".q"}, 32'(bus.q), 32'(v.expQ));
        end
    endtask

    // Build the directed vector table: fill, overflow, drain, underflow, clear
    task automatic buildVectors();
        vec_t v;
        for (int i = 0; i < 16; i++) begin
            v = '{wr: 1'b1, rd: 1'b0, clr: 1'b0, din: 16'(i + 1),
                  expUsedw: 5'(i + 1), expPeak: 5'(i + 1), expEmpty: 1'b0,
                  expFull: (i == 15), expAe: ((i + 1) <= 2), expAf: ((i + 1) >= 14),
                  expOvf: 1'b0, expUdf: 1'b0, chkQ: 1'b1, expQ: 16'h0001};
            vecs.push_back(v);
        end
        v = '{wr: 1'b1, rd: 1'b0, clr: 1'b0, din: 16'hBEEF,
              expUsedw: 5'd16, expPeak: 5'd16, expEmpty: 1'b0, expFull: 1'b1,
              expAe: 1'b0, expAf: 1'b1, expOvf: 1'b1, expUdf: 1'b0,
              chkQ: 1'b1, expQ: 16'h0001};
        vecs.push_back(v);
        for (int i = 0; i < 16; i++) begin
            v = '{wr: 1'b0, rd: 1'b1, clr: 1'b0, din: 16'h0000,
                  expUsedw: 5'(15 - i), expPeak: 5'd16, expEmpty: (i == 15),
                  expFull: 1'b0, expAe: ((15 - i) <= 2), expAf: ((15 - i) >= 14),
                  expOvf: 1'b1, expUdf: 1'b0, chkQ: (i != 15), expQ: 16'(i + 2)};
            vecs.push_back(v);
        end
        v = '{wr: 1'b0, rd: 1'b1, clr: 1'b0, din: 16'h0000,
              expUsedw: 5'd0, expPeak: 5'd16, expEmpty: 1'b1, expFull: 1'b0,
              expAe: 1'b1, expAf: 1'b0, expOvf: 1'b1, expUdf: 1'b1,
              chkQ: 1'b0, expQ: 16'h0000};
        vecs.push_back(v);
        v = '{wr: 1'b0, rd: 1'b0, clr: 1'b1, din: 16'h0000,
              expUsedw: 5'd0, expPeak: 5'd0, expEmpty: 1'b1, expFull: 1'b0,
              expAe: 1'b1, expAf: 1'b0, expOvf: 1'b0, expUdf: 1'b0,
              chkQ: 1'b0, expQ: 16'h0000};
        vecs.push_back(v);
    endtask

    initial begin
        logic [15:0] model[$];
        logic [15:0] nextWord;

        sclr_n      = 1'b0;
        bus.wrreq   = 1'b0;
        bus.rdreq   = 1'b0;
        bus.err_clr = 1'b0;
        bus.data    = 16'h0000;
        bus.ae_thr  = 5'd2;
        bus.af_thr  = 5'd14;
        buildVectors();

        // Reset state, with requests held active during reset
        doReset();
        checkOutput("reset.usedw", 32'(bus.usedw), 32'd0);
        checkOutput("reset.peak", 32'(bus.peak), 32'd0);
        checkOutput("reset.empty", 32'(bus.empty), 32'd1);
        checkOutput("reset.full", 32'(bus.full), 32'd0);
        checkOutput("reset.overflow", 32'(bus.overflow), 32'd0);
        checkOutput("reset.underflow", 32'(bus.underflow), 32'd0);
        checkOutput("reset.almost_empty", 32'(bus.almost_empty), 32'd1);
        checkOutput("reset.almost_full", 32'(bus.almost_full), 32'd0);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
            checkVector(i, vecs[i]);
        end

        // Streaming at full across pointer wrap
        doReset();
        model.delete();
        nextWord = 16'h0001;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, nextWord);
            model.push_back(nextWord);
            nextWord++;
        end
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, nextWord);
            void'(model.pop_front());
            model.push_back(nextWord);
            nextWord++;
            checkOutput($sformatf("stream%0d.usedw", i), 32'(bus.usedw), 32'd16);
            checkOutput($sformatf("stream%0d.q", i), 32'(bus.q), 32'(model[0]));
        end
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("drain%0d.q", i), 32'(bus.q), 32'(model[0]));
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
            void'(model.pop_front());
        end
        checkOutput("drain.empty", 32'(bus.empty), 32'd1);
        checkOutput("drain.underflow", 32'(bus.underflow), 32'd0);

        // Read and write together at usedw=1
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h1111);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h2222);
        checkOutput("rw1.usedw", 32'(bus.usedw), 32'd1);
        checkOutput("rw1.q", 32'(bus.q), 32'h2222);

        // Reset mid-burst discards contents
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'(16'h0300 + i));
        end
        sclr_n    = 1'b0;
        bus.wrreq = 1'b1;
        bus.data  = 16'h7777;
        @(posedge clock);
        #1;
        bus.wrreq = 1'b0;
        sclr_n    = 1'b1;
        #1;
        checkOutput("midreset.usedw", 32'(bus.usedw), 32'd0);
        checkOutput("midreset.empty", 32'(bus.empty), 32'd1);
        checkOutput("midreset.peak", 32'(bus.peak), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234);
        checkOutput("postreset.q", 32'(bus.q), 32'h1234);
        checkOutput("postreset.usedw", 32'(bus.usedw), 32'd1);

        // Simultaneous write and read into an empty FIFO
        doReset();
`ifdef SC_FIFO_BYPASS_EN
        bus.wrreq = 1'b1;
        bus.rdreq = 1'b1;
        bus.data  = 16'h00A5;
        #1;
        checkOutput("bypass.q", 32'(bus.q), 32'h00A5);
        checkOutput("bypass.empty", 32'(bus.empty), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h00A5);
        checkOutput("bypass.usedw", 32'(bus.usedw), 32'd0);
        checkOutput("bypass.underflow", 32'(bus.underflow), 32'd0);
        checkOutput("bypass.empty_after", 32'(bus.empty), 32'd1);
`else
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h00A5);
        checkOutput("emptyrw.underflow", 32'(bus.underflow), 32'd1);
        checkOutput("emptyrw.usedw", 32'(bus.usedw), 32'd1);
        checkOutput("emptyrw.empty", 32'(bus.empty), 32'd0);
        checkOutput("emptyrw.q", 32'(bus.q), 32'h00A5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
        $finish;
    end
endmodule
